// File: rtl/mp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_pkg : shared encodings for the multiply-processor blocks
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package mp_pkg;

  localparam int MP_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } booth_state_t;

  // Controller sequencing that consumes op_done in OP_CAL.
  typedef enum logic [2:0] {
    OP_IDLE  = 3'd0,
    OP_FETCH = 3'd1,
    OP_CAL   = 3'd2,
    OP_WB    = 3'd3
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/mp_booth_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_booth_enc : radix-4 Booth recoder, triplet -> {neg, one, two}
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module mp_booth_enc (
  input  logic [2:0] triplet,
  output logic       neg,
  output logic       one,
  output logic       two
);

  // 000 and 111 both mean zero, so neg is suppressed for 111.
  assign neg = triplet[2] & ~(triplet[1] & triplet[0]);
  assign one = triplet[1] ^ triplet[0];
  assign two = (triplet == 3'b011) | (triplet == 3'b100);

endmodule
`default_nettype wire

// File: rtl/mp_booth_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_booth_mul : iterative signed radix-4 Booth multiplier, WIDTH/2 cycles
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module mp_booth_mul
  import mp_pkg::*;
#(
  parameter int WIDTH = MP_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 op_done,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  booth_state_t     state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH+1:0] acc_hi;   // two guard bits keep +/-2A from overflowing
  logic [WIDTH-1:0] acc_lo;   // multiplier bits, shifted out as they are consumed
  logic             acc_prev;
  logic [CNT_W-1:0] cnt;

  logic             sel_neg;
  logic             sel_one;
  logic             sel_two;
  logic [WIDTH+1:0] mag;
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] hi_sum;
  logic [WIDTH+1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  mp_booth_enc u_enc (
    .triplet ({acc_lo[1:0], acc_prev}),
    .neg     (sel_neg),
    .one     (sel_one),
    .two     (sel_two)
  );

  always_comb begin
    mag = '0;
    if (sel_one)
      mag = {{2{a_q[WIDTH-1]}}, a_q};
    else if (sel_two)
      mag = {a_q[WIDTH-1], a_q, 1'b0};
    addend  = sel_neg ? -mag : mag;
    hi_sum  = acc_hi + addend;
    hi_next = {{2{hi_sum[WIDTH+1]}}, hi_sum[WIDTH+1:2]};
    lo_next = {hi_sum[1:0], acc_lo[WIDTH-1:2]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_done  <= 1'b0;
      busy     <= 1'b0;
      result   <= '0;
      a_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      acc_prev <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (op_clear) begin
            state   <= ST_IDLE;
            op_done <= 1'b0;
            busy    <= 1'b0;
            result  <= '0;
          end else if (op_start) begin
            state    <= ST_BUSY;
            op_done  <= 1'b0;
            busy     <= 1'b1;
            a_q      <= multiplicand;
            acc_hi   <= '0;
            acc_lo   <= multiplier;
            acc_prev <= 1'b0;
            cnt      <= '0;
          end
        end
        ST_BUSY: begin
          if (op_clear) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            result <= '0;
          end else begin
            acc_hi   <= hi_next;
            acc_lo   <= lo_next;
            acc_prev <= acc_lo[1];
            if (cnt == LAST) begin
              state   <= ST_DONE;
              busy    <= 1'b0;
              op_done <= 1'b1;
              result  <= {hi_next[WIDTH-1:0], lo_next};
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          op_done <= 1'b0;
          busy    <= 1'b0;
          result  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mp_booth_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mp_booth_mul : scoreboard bench for mp_booth_mul (WIDTH=32)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_mp_booth_mul;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           op_start;
  logic           op_clear;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           op_done;
  logic           busy;
  logic [2*W-1:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] exp_q[$];

  mp_booth_mul #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op_done      (op_done),
    .busy         (busy),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Drive a one-cycle start; optionally push the expected product.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    op_start = 1'b1; op_clear = 1'b0;
    multiplicand = a; multiplier = b;
    if (push) exp_q.push_back(model(a, b));
    tick();
    op_start = 1'b0;
  endtask

  task automatic run_to_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    while (op_done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      if (busy === 1'b1) busy_cyc++;
    end
  endtask

  function automatic logic [2*W-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic clear_op();
    op_clear = 1'b1; tick(); op_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_start = 1'b1; op_clear = 1'b0;
    multiplicand = 32'd3; multiplier = 32'd3;
    repeat (3) tick();
    vectors++;
    if (op_done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      miscompares++;
      $display("FAIL reset_state: done=%b busy=%b result=%h required 0/0/0", op_done, busy, result);
    end
    op_start = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, bc;
    logic [2*W-1:0] exp, held;
    start_op(32'd3, 32'd5, 1'b1);
    run_to_done(cyc, bc);
    exp = pop_exp();
    vectors++;
    if (cyc !== 16) begin miscompares++; $display("FAIL basic_latency: got %0d required 16", cyc); end
    vectors++;
    if (bc !== 16) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d required 16", bc); end
    vectors++;
    if (result !== exp || exp !== 64'hF) begin
      miscompares++; $display("FAIL basic_result: got %h required %h", result, 64'hF);
    end
    held = result;
    repeat (5) tick();
    vectors++;
    if (op_done !== 1'b1 || result !== held) begin
      miscompares++; $display("FAIL basic_hold: done=%b result=%h required 1/%h", op_done, result, held);
    end
    clear_op();
    vectors++;
    if (op_done !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      miscompares++; $display("FAIL basic_clear: done=%b busy=%b result=%h required 0/0/0", op_done, busy, result);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta[4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0]   tb[4] = '{32'd6,         32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [2*W-1:0] tr[4] = '{64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000,
                              64'hC000_0000_8000_0000, 64'hFFFF_FFFF_8000_0001};
    int cyc, bc;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i], 1'b1);
      run_to_done(cyc, bc);
      exp = pop_exp();
      vectors++;
      if (op_done !== 1'b1 || result !== tr[i] || exp !== tr[i]) begin
        miscompares++;
        $display("FAIL corner_%0d: done=%b result=%h required %h", i, op_done, result, tr[i]);
      end
      clear_op();
    end
  endtask

  task automatic test_start_ignored();
    int cyc, pulses;
    logic [2*W-1:0] exp;
    start_op(32'd2, 32'd2, 1'b1);
    cyc = 0;
    while (op_done !== 1'b1 && cyc < 40) begin
      if (cyc == 4) begin op_start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9; end
      else op_start = 1'b0;
      tick();
      cyc++;
    end
    op_start = 1'b0;
    exp = pop_exp();
    vectors++;
    if (cyc !== 16) begin miscompares++; $display("FAIL ignore_latency: got %0d required 16", cyc); end
    vectors++;
    if (result !== exp || exp !== 64'd4) begin
      miscompares++; $display("FAIL ignore_result: got %h required %h", result, 64'd4);
    end
    clear_op();
    pulses = 0;
    repeat (20) begin tick(); if (op_done === 1'b1) pulses++; end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL ignore_single_done: extra done cycles %0d required 0", pulses); end
  endtask

  task automatic test_abort();
    int cyc, bc, pulses;
    logic [2*W-1:0] exp;
    start_op(32'd7, 32'd7, 1'b0);
    repeat (7) tick();
    clear_op();
    vectors++;
    if (busy !== 1'b0 || op_done !== 1'b0 || result !== '0) begin
      miscompares++; $display("FAIL abort_idle: busy=%b done=%b result=%h required 0/0/0", busy, op_done, result);
    end
    pulses = 0;
    repeat (20) begin tick(); if (op_done === 1'b1 || busy === 1'b1) pulses++; end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL abort_no_done: active cycles %0d required 0", pulses); end
    start_op(32'd4, 32'd4, 1'b1);
    run_to_done(cyc, bc);
    exp = pop_exp();
    vectors++;
    if (op_done !== 1'b1 || result !== exp || exp !== 64'd16) begin
      miscompares++; $display("FAIL abort_restart: done=%b result=%h required 16", op_done, result);
    end
    clear_op();
  endtask

  task automatic test_reset_mid();
    int pulses;
    start_op(32'd11, 32'd13, 1'b0);
    repeat (9) tick();
    reset = 1'b1; op_start = 1'b1; op_clear = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || op_done !== 1'b0 || result !== '0) begin
      miscompares++; $display("FAIL reset_mid: busy=%b done=%b result=%h required 0/0/0", busy, op_done, result);
    end
    reset = 1'b0; op_start = 1'b0;
    pulses = 0;
    repeat (20) begin tick(); if (op_done === 1'b1 || busy === 1'b1) pulses++; end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL reset_mid_quiet: active cycles %0d required 0", pulses); end
  endtask

  task automatic test_start_clear();
    int cyc, bc;
    logic [2*W-1:0] exp;
    op_start = 1'b1; op_clear = 1'b1; multiplicand = 32'd5; multiplier = 32'd5;
    tick();
    op_start = 1'b0; op_clear = 1'b0;
    vectors++;
    if (busy !== 1'b0 || op_done !== 1'b0) begin
      miscompares++; $display("FAIL startclear_idle: busy=%b done=%b required 0/0", busy, op_done);
    end
    start_op(32'd5, 32'd5, 1'b0);
    repeat (3) tick();
    op_start = 1'b1; op_clear = 1'b1; tick(); op_start = 1'b0; op_clear = 1'b0;
    vectors++;
    if (busy !== 1'b0 || op_done !== 1'b0 || result !== '0) begin
      miscompares++; $display("FAIL startclear_busy: busy=%b done=%b result=%h required 0/0/0", busy, op_done, result);
    end
    start_op(32'd5, 32'd6, 1'b1);
    run_to_done(cyc, bc);
    exp = pop_exp();
    vectors++;
    if (result !== exp) begin miscompares++; $display("FAIL startclear_prod: got %h required %h", result, exp); end
    op_start = 1'b1; op_clear = 1'b1; tick(); op_start = 1'b0; op_clear = 1'b0;
    vectors++;
    if (busy !== 1'b0 || op_done !== 1'b0 || result !== '0) begin
      miscompares++; $display("FAIL startclear_done: busy=%b done=%b result=%h required 0/0/0", busy, op_done, result);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] corners[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h1};
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp;
    int cyc, bc;
    for (int n = 0; n < 1000; n++) begin
      a = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
      start_op(a, b, 1'b1);
      if (n > 0) begin
        vectors++;
        if (op_done !== 1'b0 || busy !== 1'b1) begin
          miscompares++; $display("FAIL b2b_restart_%0d: done=%b busy=%b required 0/1", n, op_done, busy);
        end
      end
      run_to_done(cyc, bc);
      exp = pop_exp();
      vectors++;
      if (cyc !== 16 || op_done !== 1'b1) begin
        miscompares++; $display("FAIL b2b_latency_%0d: cycles=%0d done=%b required 16/1", n, cyc, op_done);
      end
      vectors++;
      if (result !== exp) begin
        miscompares++; $display("FAIL b2b_result_%0d: a=%h b=%h got %h required %h", n, a, b, result, exp);
      end
    end
    clear_op();
    vectors++;
    if (exp_q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1; op_start = 1'b0; op_clear = 1'b0;
    multiplicand = '0; multiplier = '0;
    test_reset();
    test_basic();
    test_corners();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_start_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mp_booth_mul.md
MP_BOOTH_MUL -- requirements
Module: mp_booth_mul

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width in bits; it must be even and at least 4.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 Port op_start SHALL be an input, 1 bit wide: request to start a multiplication, sampled on the clock edge.
REQ-005 Port op_clear SHALL be an input, 1 bit wide: abort or acknowledge; returns the block to IDLE.
REQ-006 Port multiplicand SHALL be an input, WIDTH bits wide: signed two's-complement operand A, sampled with op_start.
REQ-007 Port multiplier SHALL be an input, WIDTH bits wide: signed two's-complement operand B, sampled with op_start.
REQ-008 Port op_done SHALL be an output, 1 bit wide: result valid; consumed by the controller's OP_CAL state.
REQ-009 Port busy SHALL be an output, 1 bit wide: high while iterating.
REQ-010 Port result SHALL be an output, 2*WIDTH bits wide: signed product A*B.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE, all outputs registered.
REQ-012 In IDLE, op_start=1 with op_clear=0 at an edge SHALL latch both operands, clear the accumulator, zero the iteration counter and enter BUSY.
REQ-013 In BUSY, each cycle SHALL perform one radix-4 Booth step:
- recode the triplet {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0, to a digit in {0, +A, +2A, -A, -2A};
- add that digit to the upper accumulator;
- arithmetic-shift the accumulator right by 2.
REQ-014 The internal accumulator SHALL be at least WIDTH+2 bits in its upper part so that ±2A never overflows, including for A = -2^(WIDTH-1).
REQ-015 BUSY SHALL last exactly WIDTH/2 cycles; at the edge ending the last iteration, result SHALL be loaded and the state SHALL become DONE.
REQ-016 Latency: if op_start is sampled at edge E0, op_done SHALL first be high after edge E0+WIDTH/2 (16 cycles for WIDTH=32).
REQ-017 busy SHALL be 1 exactly while the state is BUSY; op_done SHALL be 1 exactly while the state is DONE.
REQ-018 In DONE, op_done and result SHALL hold until op_clear or op_start.
REQ-019 In DONE, op_clear=1 SHALL move the block to IDLE and zero result.
REQ-020 In DONE, op_start=1 with op_clear=0 SHALL restart exactly as from IDLE, and op_done SHALL fall on the next cycle.
REQ-021 In BUSY, op_start SHALL be ignored and the operands SHALL NOT be re-sampled.
REQ-022 In BUSY, op_clear=1 SHALL abort to IDLE, zero result, and never assert op_done for the aborted operation.
REQ-023 When op_start and op_clear are asserted together, op_clear SHALL win in every state.
REQ-024 result SHALL be exact for all signed operand pairs, including the product (-2^(WIDTH-1))*(-2^(WIDTH-1)) = 2^(2*WIDTH-2).
REQ-025 An unreachable state encoding SHALL return the FSM to IDLE on the next edge.

Reset
REQ-026 reset=1 at a clock edge SHALL force: state IDLE, op_done=0, busy=0, result=0, accumulator=0, counter=0.
REQ-027 reset SHALL override op_start and op_clear in every state, including mid-BUSY, and the aborted operation SHALL produce no op_done.
REQ-028 The first op_start honoured after reset is deasserted SHALL be one sampled at an edge where reset=0.

Structure
REQ-029 The state encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the WIDTH default SHALL reside in the shared package mp_pkg, beside the controller state constants.
REQ-030 Booth recoding SHALL be one combinational sub-module, mp_booth_enc, taking a 3-bit triplet and producing neg, one and two selects.
REQ-031 The FSM, counter and accumulator datapath SHALL reside in mp_booth_mul.

Verification
REQ-032 Basic product: A=3, B=5, op_start for one cycle -> busy high for 16 cycles, then op_done=1 and result=0x0000_0000_0000_000F, held until op_clear.
REQ-033 Signed and corner products:
- A=-7, B=6 -> result=0xFFFF_FFFF_FFFF_FFD6;
- A=B=0x8000_0000 -> result=0x4000_0000_0000_0000;
- A=0x7FFF_FFFF, B=0x8000_0000 -> result=0xC000_0000_8000_0000.
REQ-034 Start ignored while busy: op_start with A=2, B=2; second op_start at cycle 5 with A=9, B=9 -> single op_done at cycle 16, result=4.
REQ-035 Abort mid-operation: op_clear at cycle 8 of BUSY -> IDLE next cycle, result=0, op_done never asserted; a subsequent op_start (A=4, B=4) -> result=16.
REQ-036 Reset mid-operation: reset at cycle 10 of BUSY -> all outputs zero next cycle. Simultaneous start and clear: op_start=op_clear=1 in IDLE -> stays IDLE.
REQ-037 Randomized check: 1000 random signed pairs compared against a reference model, with back-to-back restarts from DONE.
